// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides. Single-cycle ops finish
// in one clock; MUL is an iterative shift-add over WIDTH clocks.
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int OP_W  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [OP_W-1:0]      op,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic                 carry,
   output logic                 ovf,
   output logic                 zero,
   output logic                 neg,
   output logic                 error
);
   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
   localparam logic [OP_W-1:0] OP_AND = OP_W'(2);
   localparam logic [OP_W-1:0] OP_OR  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_XOR = OP_W'(4);
   localparam logic [OP_W-1:0] OP_SHL = OP_W'(5);
   localparam logic [OP_W-1:0] OP_SHR = OP_W'(6);
   localparam logic [OP_W-1:0] OP_MUL = OP_W'(7);
   localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t              state_q;
   logic                in_ready_q, out_valid_q;
   logic [RW-1:0]       result_q;
   logic                carry_q, ovf_q, zero_q, neg_q, error_q;
   logic [WIDTH-1:0]    mcand_q;
   logic [RW-1:0]       mplier_q, acc_q;
   logic [CW-1:0]       cnt_q;

   logic [WIDTH:0]      sum_w;
   logic [WIDTH-1:0]    diff_w, shl_w, shr_w;
   logic [RW-1:0]       alu_res_d, acc_d;
   logic                alu_c_d, alu_v_d, alu_err_d;

   assign sum_w  = {1'b0, a} + {1'b0, b};
   assign diff_w = a - b;
   assign shl_w  = a << b;
   assign shr_w  = a >> b;
   assign acc_d  = acc_q + (mcand_q[0] ? mplier_q : '0);

   always_comb begin
      alu_res_d = '0;
      alu_c_d   = 1'b0;
      alu_v_d   = 1'b0;
      alu_err_d = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res_d = {{(WIDTH-1){1'b0}}, sum_w};
            alu_c_d   = sum_w[WIDTH];
            alu_v_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res_d = {{WIDTH{1'b0}}, diff_w};
            alu_c_d   = (a < b);
            alu_v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: alu_res_d = {{WIDTH{1'b0}}, a & b};
         OP_OR:  alu_res_d = {{WIDTH{1'b0}}, a | b};
         OP_XOR: alu_res_d = {{WIDTH{1'b0}}, a ^ b};
         OP_SHL: if (b < SHIFT_LIM) alu_res_d = {{WIDTH{1'b0}}, shl_w};
         OP_SHR: if (b < SHIFT_LIM) alu_res_d = {{WIDTH{1'b0}}, shr_w};
         OP_MUL: alu_res_d = '0;
         default: alu_err_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
         error_q     <= 1'b0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               in_ready_q <= 1'b0;
               if (op == OP_MUL) begin
                  mcand_q  <= a;
                  mplier_q <= {{WIDTH{1'b0}}, b};
                  acc_q    <= '0;
                  cnt_q    <= CW'(WIDTH);
                  state_q  <= S_MUL;
               end else begin
                  result_q    <= alu_res_d;
                  carry_q     <= alu_c_d;
                  ovf_q       <= alu_v_d;
                  zero_q      <= (alu_res_d == '0);
                  neg_q       <= alu_res_d[WIDTH-1];
                  error_q     <= alu_err_d;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_MUL: begin
               acc_q    <= acc_d;
               mplier_q <= mplier_q << 1;
               mcand_q  <= mcand_q >> 1;
               cnt_q    <= cnt_q - CW'(1);
               // Last partial product is folded straight into the result register.
               if (cnt_q == CW'(1)) begin
                  result_q    <= acc_d;
                  carry_q     <= 1'b0;
                  ovf_q       <= 1'b0;
                  zero_q      <= (acc_d == '0);
                  neg_q       <= 1'b0;
                  error_q     <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carry     = carry_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign neg       = neg_q;
   assign error     = error_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): expected results are queued at issue
// time and popped when out_valid appears.
module tb_alu_seq;
   localparam int W = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic [W-1:0]    a = '0;
   logic [W-1:0]    b = '0;
   logic [3:0]      op = '0;
   logic            in_ready, out_valid, carry, ovf, zero, neg, error;
   logic [2*W-1:0]  result;

   typedef struct {
      logic [31:0] res;
      logic        c, v, z, n, e;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   alu_seq #(.WIDTH(W), .OP_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry(carry), .ovf(ovf), .zero(zero), .neg(neg), .error(error)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic [31:0] r, input logic c, v, z, n, e, input int lat);
      exp_t x;
      x.res = r; x.c = c; x.v = v; x.z = z; x.n = n; x.e = e; x.lat = lat;
      return x;
   endfunction

   // Reference model written with plain 32-bit integer arithmetic.
   function automatic exp_t model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
      exp_t        r;
      int unsigned ux, uy, t;
      ux = x; uy = y;
      r = mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      case (o)
         4'd0: begin
            t = ux + uy; r.res = t;
            r.c = (t > 32'hFFFF);
            r.v = (x[15] == y[15]) && (t[15] != x[15]);
         end
         4'd1: begin
            t = (ux - uy) & 32'hFFFF; r.res = t;
            r.c = (ux < uy);
            r.v = (x[15] != y[15]) && (t[15] != x[15]);
         end
         4'd2: r.res = ux & uy;
         4'd3: r.res = ux | uy;
         4'd4: r.res = ux ^ uy;
         4'd5: r.res = (uy >= 16) ? 32'h0 : ((ux << uy) & 32'hFFFF);
         4'd6: r.res = (uy >= 16) ? 32'h0 : (ux >> uy);
         4'd7: begin r.res = ux * uy; r.lat = 17; end
         default: r.e = 1'b1;
      endcase
      r.z = (r.res == 32'h0);
      r.n = (o <= 4'd6) ? r.res[15] : 1'b0;
      return r;
   endfunction

   task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                        input exp_t e, input bit push);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL issue_ready: in_ready=%b required 1 (op=%0d)", in_ready, o);
      end
      op = o; a = x; b = y; in_valid = 1'b1;
      if (push) sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
   endtask

   task automatic collect(input int hold);
      int          lat;
      exp_t        e;
      logic [31:0] held;
      lat = 1;
      @(negedge clk);
      while (out_valid !== 1'b1 && lat < 64) begin
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_ready: in_ready=%b required 0 at lat %0d", in_ready, lat);
         end
         in_valid = 1'b1; op = 4'($urandom);
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout: out_valid=%b required 1 within 64 cycles", out_valid);
      end
      if (sb.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard: queue size 0 required >0");
         return;
      end
      e = sb.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin
         n_bad++;
         $display("FAIL latency: got %0d required %0d", lat, e.lat);
      end
      n_cmp++;
      if (result !== e.res) begin
         n_bad++;
         $display("FAIL result: got %h required %h", result, e.res);
      end
      n_cmp++;
      if ({carry, ovf, zero, neg, error} !== {e.c, e.v, e.z, e.n, e.e}) begin
         n_bad++;
         $display("FAIL flags(c,v,z,n,e): got %b required %b", {carry, ovf, zero, neg, error},
                  {e.c, e.v, e.z, e.n, e.e});
      end
      $display("txn: result=%h flags=%b lat=%0d", result, {carry, ovf, zero, neg, error}, lat);
      held = e.res;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); op = 4'd0;
         @(negedge clk);
         n_cmp++;
         if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold[%0d]: result=%h ov=%b ir=%b required %h 1 0", i, result,
                     out_valid, in_ready, held);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 ||
          {carry, ovf, zero, neg, error} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset: ir=%b ov=%b result=%h flags=%b required 1 0 0 0", in_ready,
                  out_valid, result, {carry, ovf, zero, neg, error});
      end
      $display("txn: reset checked");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      issue(4'd0, 16'hFFFF, 16'h0001, mk(32'h0001_0000, 1, 0, 0, 0, 0, 1), 1'b1);
      collect(0);
      issue(4'd0, 16'h7FFF, 16'h0001, mk(32'h0000_8000, 0, 1, 0, 1, 0, 1), 1'b1);
      collect(0);
   endtask

   task automatic test_sub();
      issue(4'd1, 16'd3, 16'd5, mk(32'h0000_FFFE, 1, 0, 0, 1, 0, 1), 1'b1);
      collect(0);
      issue(4'd1, 16'd5, 16'd5, mk(32'h0, 0, 0, 1, 0, 0, 1), 1'b1);
      collect(0);
   endtask

   task automatic test_mul_hold();
      issue(4'd7, 16'hFFFF, 16'hFFFF, mk(32'hFFFE_0001, 0, 0, 0, 0, 0, 17), 1'b1);
      collect(5);
   endtask

   task automatic test_logic_shift_illegal();
      issue(4'd2, 16'hF0F0, 16'hFF00, mk(32'h0000_F000, 0, 0, 0, 1, 0, 1), 1'b1);
      collect(0);
      issue(4'd3, 16'h00F0, 16'h0F00, mk(32'h0000_0FF0, 0, 0, 0, 0, 0, 1), 1'b1);
      collect(0);
      issue(4'd4, 16'hF0F0, 16'hF0F0, mk(32'h0, 0, 0, 1, 0, 0, 1), 1'b1);
      collect(0);
      issue(4'd5, 16'h0001, 16'd4, mk(32'h0000_0010, 0, 0, 0, 0, 0, 1), 1'b1);
      collect(0);
      issue(4'd5, 16'h0001, 16'd15, mk(32'h0000_8000, 0, 0, 0, 1, 0, 1), 1'b1);
      collect(0);
      issue(4'd6, 16'h8000, 16'd16, mk(32'h0, 0, 0, 1, 0, 0, 1), 1'b1);
      collect(0);
      issue(4'hA, 16'h1234, 16'h5678, mk(32'h0, 0, 0, 1, 0, 1, 1), 1'b1);
      collect(2);
   endtask

   task automatic test_reset_mid_mul();
      issue(4'd7, 16'h1234, 16'h5678, mk(32'h0, 0, 0, 0, 0, 0, 17), 1'b0);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin
         n_bad++;
         $display("FAIL mid_mul_reset: ov=%b ir=%b result=%h required 0 1 0", out_valid,
                  in_ready, result);
      end
      $display("txn: reset during MUL checked");
      @(negedge clk);
      rst_n = 1'b1;
      issue(4'd0, 16'd2, 16'd3, mk(32'h5, 0, 0, 0, 0, 0, 1), 1'b1);
      collect(0);
   endtask

   task automatic test_back_to_back();
      logic [3:0]  o;
      logic [15:0] x, y;
      for (int i = 0; i < 16; i++) begin
         o = (i % 5 == 4) ? 4'd7 : 4'($urandom_range(0, 10));
         x = 16'($urandom);
         y = (o == 4'd5 || o == 4'd6) ? 16'($urandom_range(12, 18)) : 16'($urandom);
         issue(o, x, y, model(o, x, y), 1'b1);
         collect(i % 3);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul_hold();
      test_logic_shift_illegal();
      test_reset_mid_mul();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
